counter_bank: RTL and testbench

Parametrised bank of N_CH independent up/down counters sharing one clock and one prescaler. It is the successor to the two-counter sample design and is driven directly from wire-in and trigger-in endpoints. Each channel supports reset, single-step up/down, prescaled autocount in either direction, and wrap or saturate mode. Registered zero-match, compare-match and wrap strobes are sized to feed trigger-out endpoints.

---
 rtl/counter_bank_pkg.sv | 39 +++
 rtl/counter_bank_ch.sv | 100 ++++++++++
 rtl/counter_bank.sv | 101 ++++++++++
 tb/tb_counter_bank.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared types and helpers for the counter_bank block.
// Holds the per-channel command enumeration and the fixed-priority resolver
// that turns the raw control inputs of one channel into a single command.
package counter_bank_pkg;

  // One resolved action per channel per clock.
  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLR,
    CMD_UP,
    CMD_DOWN,
    CMD_AUTO
  } cmd_e;

  // Fixed priority: clear, step up, step down, prescaled autocount, hold.
  // Autocount only counts as a command on a prescaler tick.
  function automatic cmd_e resolve_cmd(
    input logic clr,
    input logic up,
    input logic down,
    input logic auto_en,
    input logic tick
  );
    cmd_e cmd;
    if (clr) begin
      cmd = CMD_CLR;
    end else if (up) begin
      cmd = CMD_UP;
    end else if (down) begin
      cmd = CMD_DOWN;
    end else if (auto_en && tick) begin
      cmd = CMD_AUTO;
    end else begin
      cmd = CMD_HOLD;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// counter_bank_ch: one channel of the counter bank.
// Unsigned WIDTH-bit up/down counter with wrap or saturate behaviour,
// a registered wrap strobe, and rising-edge match detectors for zero and
// for the channel's compare value. The match history registers reset to 1
// so that the reset value of the count never produces a pulse.
module counter_bank_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ch_reset_i,
  input  logic             ch_up_i,
  input  logic             ch_down_i,
  input  logic             ch_auto_i,
  input  logic             ch_dir_i,
  input  logic             ch_sat_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] cmp_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             eq_zero_o,
  output logic             eq_cmp_o,
  output logic             wrapped_o
);

  import counter_bank_pkg::*;

  localparam logic [WIDTH-1:0] MaxVal = '1;

  cmd_e             cmd;
  logic             go_up;
  logic             go_dn;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             m_zero;
  logic             m_cmp;
  logic             m_zero_prev_q;
  logic             m_cmp_prev_q;
  logic             eq_zero_q;
  logic             eq_cmp_q;

  assign cmd   = resolve_cmd(ch_reset_i, ch_up_i, ch_down_i, ch_auto_i, tick_i);
  assign go_up = (cmd == CMD_UP)   || ((cmd == CMD_AUTO) && !ch_dir_i);
  assign go_dn = (cmd == CMD_DOWN) || ((cmd == CMD_AUTO) &&  ch_dir_i);

  // Matches are judged on the registered count against the live compare value.
  assign m_zero = (count_q == '0);
  assign m_cmp  = (count_q == cmp_value_i);

  // Next count and wrap strobe from the resolved command.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (cmd == CMD_CLR) begin
      count_d = '0;
    end else if (go_up) begin
      if (count_q != MaxVal) begin
        count_d = count_q + WIDTH'(1);
      end else if (!ch_sat_i) begin
        count_d   = '0;
        wrapped_d = 1'b1;
      end
    end else if (go_dn) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (!ch_sat_i) begin
        count_d   = MaxVal;
        wrapped_d = 1'b1;
      end
    end
  end

  // Count, wrap strobe and match edge detectors.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      count_q       <= '0;
      wrapped_q     <= 1'b0;
      m_zero_prev_q <= 1'b1;
      m_cmp_prev_q  <= 1'b1;
      eq_zero_q     <= 1'b0;
      eq_cmp_q      <= 1'b0;
    end else begin
      count_q       <= count_d;
      wrapped_q     <= wrapped_d;
      m_zero_prev_q <= m_zero;
      m_cmp_prev_q  <= m_cmp;
      eq_zero_q     <= m_zero & ~m_zero_prev_q;
      eq_cmp_q      <= m_cmp & ~m_cmp_prev_q;
    end
  end

  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;
  assign eq_zero_o = eq_zero_q;
  assign eq_cmp_o  = eq_cmp_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: N_CH independent up/down counters sharing one prescaler.
// The prescaler strobes tick for one cycle every DIV_LOAD+1 clocks; each
// channel (counter_bank_ch) autocounts on that strobe when enabled.
// Optional feature macro: COUNTER_BANK_CAPTURE_EN adds the capture input and
// the cap_count output, a coherent snapshot of all channel counts.
module counter_bank #(
  parameter int               N_CH     = 4,
  parameter int               WIDTH    = 8,
  parameter int               DIV_W    = 24,
  parameter logic [DIV_W-1:0] DIV_LOAD = 24'h400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ch_reset,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       ch_dir,
  input  logic [N_CH-1:0]       ch_sat,
  input  logic [N_CH*WIDTH-1:0] cmp_value,
`ifdef COUNTER_BANK_CAPTURE_EN
  input  logic                  capture,
  output logic [N_CH*WIDTH-1:0] cap_count,
`endif
  output logic [N_CH*WIDTH-1:0] count,
  output logic                  tick,
  output logic [N_CH-1:0]       eq_zero,
  output logic [N_CH-1:0]       eq_cmp,
  output logic [N_CH-1:0]       wrapped
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_q;
  logic             tick_d;

  // Prescaler next state: count down, reload and strobe when it reaches zero.
  always_comb begin
    div_d  = div_q - DIV_W'(1);
    tick_d = 1'b0;
    if (div_q == '0) begin
      div_d  = DIV_LOAD;
      tick_d = 1'b1;
    end
  end

  // Prescaler registers; starts full so the first tick is DIV_LOAD+1 clocks out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= DIV_LOAD;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // One independent channel per bit/slice; only the tick is shared.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i       (clk),
      .reset_i     (reset),
      .ch_reset_i  (ch_reset[i]),
      .ch_up_i     (ch_up[i]),
      .ch_down_i   (ch_down[i]),
      .ch_auto_i   (ch_auto[i]),
      .ch_dir_i    (ch_dir[i]),
      .ch_sat_i    (ch_sat[i]),
      .tick_i      (tick_q),
      .cmp_value_i (cmp_value[i*WIDTH +: WIDTH]),
      .count_o     (count[i*WIDTH +: WIDTH]),
      .eq_zero_o   (eq_zero[i]),
      .eq_cmp_o    (eq_cmp[i]),
      .wrapped_o   (wrapped[i])
    );
  end

`ifdef COUNTER_BANK_CAPTURE_EN
  logic [N_CH*WIDTH-1:0] cap_q;
  logic [N_CH*WIDTH-1:0] cap_d;

  // The snapshot takes the registered counts, i.e. values before this edge's update.
  assign cap_d = capture ? count : cap_q;

  // Capture register holding the last coherent snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign cap_count = cap_q;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: self-checking bench for counter_bank.
// Directed table vectors, hand-written corner sequences and a randomized run
// against a behavioural model. Capture checks follow COUNTER_BANK_CAPTURE_EN.
module tb_counter_bank;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int DW   = 4;
  localparam int L    = 3;
  localparam int L7   = 7;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   ch_reset = '0;
  logic [N-1:0]   ch_up = '0;
  logic [N-1:0]   ch_down = '0;
  logic [N-1:0]   ch_auto = '0;
  logic [N-1:0]   ch_dir = '0;
  logic [N-1:0]   ch_sat = '0;
  logic [N*W-1:0] cmp_value = '0;
  logic           capture = 1'b0;
  logic [N*W-1:0] count, count7;
  logic           tick, tick7;
  logic [N-1:0]   eq_zero, eq_cmp, wrapped;
  logic [N-1:0]   eq_zero7, eq_cmp7, wrapped7;
`ifdef COUNTER_BANK_CAPTURE_EN
  logic [N*W-1:0] cap_count, cap_count7;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  int           mcnt[N];
  int           mcap[N];
  bit           pz[N];
  bit           pc[N];
  bit           mtick;
  int           n_edge;
  logic [N-1:0] e_wr, e_eqz, e_eqc;

  always #5 clk = ~clk;

  counter_bank #(.N_CH(N), .WIDTH(W), .DIV_W(DW), .DIV_LOAD(DW'(L))) dut (
    .clk(clk), .reset(reset), .ch_reset(ch_reset), .ch_up(ch_up), .ch_down(ch_down),
    .ch_auto(ch_auto), .ch_dir(ch_dir), .ch_sat(ch_sat), .cmp_value(cmp_value),
`ifdef COUNTER_BANK_CAPTURE_EN
    .capture(capture), .cap_count(cap_count),
`endif
    .count(count), .tick(tick), .eq_zero(eq_zero), .eq_cmp(eq_cmp), .wrapped(wrapped)
  );

  counter_bank #(.N_CH(N), .WIDTH(W), .DIV_W(DW), .DIV_LOAD(DW'(L7))) dut7 (
    .clk(clk), .reset(reset), .ch_reset(ch_reset), .ch_up(ch_up), .ch_down(ch_down),
    .ch_auto(ch_auto), .ch_dir(ch_dir), .ch_sat(ch_sat), .cmp_value(cmp_value),
`ifdef COUNTER_BANK_CAPTURE_EN
    .capture(capture), .cap_count(cap_count7),
`endif
    .count(count7), .tick(tick7), .eq_zero(eq_zero7), .eq_cmp(eq_cmp7), .wrapped(wrapped7)
  );

  typedef struct {
    logic [N-1:0]   rst;
    logic [N-1:0]   up;
    logic [N-1:0]   dn;
    logic [N*W-1:0] exp_cnt;
    logic [N-1:0]   exp_wr;
    logic [N-1:0]   exp_eqz;
    logic [N-1:0]   exp_eqc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    mtick  = 1'b0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      mcap[i] = 0;
      pz[i]   = 1'b1;
      pc[i]   = 1'b1;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock edge; the model consumes the inputs present at that edge.
  task automatic step();
    int c, nx, delta;
    @(posedge clk);
    n_edge++;
    for (int i = 0; i < N; i++) begin
      c = mcnt[i];
      e_eqz[i] = (c == 0) && !pz[i];
      pz[i]    = (c == 0);
      e_eqc[i] = (c == int'(cmp_value[i*W +: W])) && !pc[i];
      pc[i]    = (c == int'(cmp_value[i*W +: W]));
      e_wr[i]  = 1'b0;
      if (capture) mcap[i] = c;
      if (ch_reset[i]) begin
        nx = 0;
      end else begin
        delta = 0;
        if (ch_up[i])                  delta = 1;
        else if (ch_down[i])           delta = -1;
        else if (ch_auto[i] && mtick)  delta = ch_dir[i] ? -1 : 1;
        nx = c + delta;
        if (nx > MAXV || nx < 0) begin
          if (ch_sat[i]) nx = c;
          else begin
            nx = (nx + MAXV + 1) % (MAXV + 1);
            e_wr[i] = 1'b1;
          end
        end
      end
      mcnt[i] = nx;
    end
    mtick = ((n_edge % (L + 1)) == 0);
    #1;
  endtask

  task automatic compare_model(input int cyc);
    logic [N*W-1:0] ec, ecap;
    for (int i = 0; i < N; i++) begin
      ec[i*W +: W]   = W'(mcnt[i]);
      ecap[i*W +: W] = W'(mcap[i]);
    end
    check($sformatf("rnd%0d count", cyc), count, ec);
    check($sformatf("rnd%0d tick", cyc), tick, mtick);
    check($sformatf("rnd%0d eq_zero", cyc), eq_zero, e_eqz);
    check($sformatf("rnd%0d eq_cmp", cyc), eq_cmp, e_eqc);
    check($sformatf("rnd%0d wrapped", cyc), wrapped, e_wr);
`ifdef COUNTER_BANK_CAPTURE_EN
    check($sformatf("rnd%0d cap_count", cyc), cap_count, ecap);
`else
    if (ecap != ecap) n_err++;
`endif
  endtask

  task automatic idle_inputs();
    ch_reset = '0; ch_up = '0; ch_down = '0; ch_auto = '0; ch_dir = '0; capture = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    vec_t tbl[14];
    int   pulses, k;
    logic wr_seen;

    model_reset();
    reset_dut();

    // Reset state
    check("reset count", count, 0);
    check("reset tick", tick, 0);
    check("reset eq_zero", eq_zero, 0);
    check("reset eq_cmp", eq_cmp, 0);
    check("reset wrapped", wrapped, 0);
    check("reset tick7", tick7, 0);

    // First tick after DIV_LOAD+1 clocks, no pulses while idle
    for (int n = 1; n <= 9; n++) begin
      step();
      check($sformatf("tick edge%0d", n), tick, (n % (L + 1)) == 0);
      check($sformatf("tick7 edge%0d", n), tick7, (n % (L7 + 1)) == 0);
      check($sformatf("idle pulses edge%0d", n), {eq_zero, eq_cmp, wrapped}, 0);
      check($sformatf("idle count edge%0d", n), count, 0);
    end

    // Table: ch0 wrap, ch1 saturate at 0, ch3 steps, ch2 priority
    ch_sat    = 4'b0010;
    cmp_value = {8'd10, 8'd0, 8'd0, 8'hFF};
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0001, 32'h000000FF, 4'b0001, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0001, 4'b0000, 32'h00000000, 4'b0001, 4'b0000, 4'b0001};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0001, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0010, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0010, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0010, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b1000, 4'b0000, 32'h01000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b1000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b1000, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0100, 4'b0100, 32'h00010000, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0100, 4'b0100, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0100, 4'b0100};
    for (int r = 0; r < 14; r++) begin
      ch_reset = tbl[r].rst;
      ch_up    = tbl[r].up;
      ch_down  = tbl[r].dn;
      step();
      check($sformatf("row%0d count", r), count, tbl[r].exp_cnt);
      check($sformatf("row%0d wrapped", r), wrapped, tbl[r].exp_wr);
      check($sformatf("row%0d eq_zero", r), eq_zero, tbl[r].exp_eqz);
      check($sformatf("row%0d eq_cmp", r), eq_cmp, tbl[r].exp_eqc);
    end
    idle_inputs();

    // ch3: reset beats up and down; up beats down
    ch_up = 4'b1000;
    repeat (9) step();
    check("ch3 at 9", count[3*W +: W], 9);
    ch_reset = 4'b1000; ch_down = 4'b1000;
    step();
    check("ch3 rst+up+dn", count[3*W +: W], 0);
    check("ch3 rst no wrap", wrapped[3], 0);
    ch_reset = '0; ch_down = '0;
    repeat (9) step();
    ch_down = 4'b1000;
    step();
    check("ch3 up+dn", count[3*W +: W], 10);
    idle_inputs();
    step();
    check("ch3 eq_cmp pulse", eq_cmp[3], 1);
    step();
    check("ch3 eq_cmp once", eq_cmp[3], 0);

    // ch2: autocount down from 5 on the prescaler tick
    ch_reset = 4'b0100;
    step();
    ch_reset = '0; ch_up = 4'b0100;
    repeat (5) step();
    ch_up = '0;
    cmp_value[2*W +: W] = 8'd3;
    ch_dir = 4'b0100; ch_auto = 4'b0100;
    pulses = 0; k = 0;
    while (count[2*W +: W] == 8'd5 && k < 2 * (L + 1)) begin
      step();
      pulses += int'(eq_cmp[2]);
      k++;
    end
    check("auto first step", count[2*W +: W], 4);
    for (int s = 1; s <= L + 1; s++) begin
      step();
      pulses += int'(eq_cmp[2]);
      check($sformatf("auto to 3 s%0d", s), count[2*W +: W], (s == L + 1) ? 3 : 4);
    end
    for (int s = 1; s <= L + 1; s++) begin
      step();
      pulses += int'(eq_cmp[2]);
      check($sformatf("auto to 2 s%0d", s), count[2*W +: W], (s == L + 1) ? 2 : 3);
    end
    repeat (2) begin
      step();
      pulses += int'(eq_cmp[2]);
    end
    check("auto eq_cmp pulses", pulses, 1);
    idle_inputs();

    // ch1: saturate at max, then wrap once saturation is released
    ch_up = 4'b0010; wr_seen = 1'b0;
    repeat (MAXV) begin
      step();
      wr_seen |= wrapped[1];
    end
    check("sat reach max", count[1*W +: W], MAXV);
    repeat (3) begin
      step();
      wr_seen |= wrapped[1];
    end
    check("sat hold max", count[1*W +: W], MAXV);
    check("sat no wrap", wr_seen, 0);
    ch_sat = '0;
    step();
    check("wrap max to 0", count[1*W +: W], 0);
    check("wrap pulse", wrapped[1], 1);
    ch_up = '0;
    step();
    check("wrap pulse width", wrapped[1], 0);
    check("wrap eq_zero", eq_zero[1], 1);

    // Randomized run against the model, with an async reset mid-run
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        ch_reset[i] = ($urandom_range(0, 49) == 0);
        ch_up[i]    = ($urandom_range(0, 3) == 0);
        ch_down[i]  = ($urandom_range(0, 3) == 0);
        ch_auto[i]  = ($urandom_range(0, 1) == 1);
        ch_dir[i]   = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 7) == 0) ch_sat[i] = ~ch_sat[i];
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       cmp_value[i*W +: W] = W'($urandom_range(0, 2));
            1:       cmp_value[i*W +: W] = W'(MAXV - int'($urandom_range(0, 1)));
            default: cmp_value[i*W +: W] = W'($urandom_range(0, MAXV));
          endcase
        end
      end
      capture = ($urandom_range(0, 3) == 0);
      if (cyc == 200) begin
        reset = 1'b1;
        #1;
        check("async count", count, 0);
        check("async tick", tick, 0);
        check("async pulses", {eq_zero, eq_cmp, wrapped}, 0);
`ifdef COUNTER_BANK_CAPTURE_EN
        check("async cap_count", cap_count, 0);
`endif
        reset_dut();
      end
      step();
      compare_model(cyc);
    end
    idle_inputs();
    ch_sat = '0;

`ifdef COUNTER_BANK_CAPTURE_EN
    // Capture in the same cycle as a step takes the pre-update value
    ch_reset = 4'b0001;
    step();
    ch_reset = '0; ch_up = 4'b0001;
    repeat (4) step();
    capture = 1'b1;
    step();
    check("capture ch0", cap_count[W-1:0], 4);
    check("capture count ch0", count[W-1:0], 5);
    compare_model(1000);
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
